// File: rtl/ioctl_region_loader.sv
// HPS ioctl download steering: ROM bytes go to per-region SDRAM ports via a
// req/ack toggle handshake, DIP bytes land in a local register, core reset is held after load.
module ioctl_region_loader #(
  parameter int                          NUM_REGIONS = 4,
  parameter logic [25*NUM_REGIONS-1:0]   REGION_BASE = {25'h10000, 25'h0A000, 25'h08000, 25'h00000},
  parameter logic [25*NUM_REGIONS-1:0]   REGION_END  = {25'h1C000, 25'h10000, 25'h0A000, 25'h08000},
  parameter int                          ADDR_W      = 23,
  parameter int                          ROM_INDEX   = 0,
  parameter int                          DIP_INDEX   = 254,
  parameter int                          DIP_BYTES   = 8,
  parameter int                          RESET_HOLD  = 65535,
  parameter int                          ACK_TIMEOUT = 255
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic [7:0]               ioctl_index,
  output logic                     ioctl_wait,
  output logic [NUM_REGIONS-1:0]   port_req,
  input  logic [NUM_REGIONS-1:0]   port_ack,
  output logic [ADDR_W-1:0]        port_a,
  output logic [1:0]               port_ds,
  output logic [15:0]              port_d,
  input  logic                     user_reset,
  output logic                     core_reset,
  output logic                     rom_loaded,
  output logic [8*DIP_BYTES-1:0]   dip_sw,
  output logic [7:0]               err_unmapped,
  output logic                     err_timeout
);

  localparam int SEL_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int TMR_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
  localparam logic [7:0] ROM_IDX = 8'(ROM_INDEX);
  localparam logic [7:0] DIP_IDX = 8'(DIP_INDEX);

  typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

  state_t                   state_q, state_d;
  logic [NUM_REGIONS-1:0]   req_q, req_d;
  logic [ADDR_W-1:0]        a_q, a_d;
  logic [1:0]               ds_q, ds_d;
  logic [15:0]              d_q, d_d;
  logic                     wait_q, wait_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [7:0]               errc_q, errc_d;
  logic                     errt_q, errt_d;
  logic [8*DIP_BYTES-1:0]   dip_q, dip_d;
  logic                     wr_q, dl_q;
  logic [7:0]               idx_q, idx_d;
  logic                     loaded_q, loaded_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     core_q, core_d;

  logic                     ev, rom_ev, dip_ev, hit;
  logic [SEL_W-1:0]         hit_idx;
  logic [24:0]              hit_base;
  logic [ADDR_W:0]          off;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Region decode: scanning downward lets the lowest matching region win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (ioctl_addr >= REGION_BASE[25*i +: 25] && ioctl_addr < REGION_END[25*i +: 25]) begin
        hit      = 1'b1;
        hit_idx  = SEL_W'(i);
        hit_base = REGION_BASE[25*i +: 25];
      end
    end
    off = (ADDR_W + 1)'(ioctl_addr - hit_base);
  end

  always_comb begin
    ev     = ioctl_download & ioctl_wr & ~wr_q;
    rom_ev = ev & (ioctl_index == ROM_IDX);
    dip_ev = ev & (ioctl_index == DIP_IDX) & (ioctl_addr < 25'(DIP_BYTES));

    state_d  = state_q;
    req_d    = req_q;
    a_d      = a_q;
    ds_d     = ds_q;
    d_d      = d_q;
    wait_d   = wait_q;
    sel_d    = sel_q;
    tmr_d    = tmr_q;
    errc_d   = errc_q;
    errt_d   = errt_q;
    dip_d    = dip_q;

    case (state_q)
      IDLE: begin
        if (rom_ev) begin
          if (hit) begin
            a_d            = off[ADDR_W:1];
            ds_d           = {off[0], ~off[0]};
            d_d            = {ioctl_dout, ioctl_dout};
            req_d[hit_idx] = ~req_q[hit_idx];
            wait_d         = 1'b1;
            sel_d          = hit_idx;
            tmr_d          = '0;
            state_d        = WAIT_ACK;
          end else begin
            errc_d = sat_inc(errc_q);
          end
        end
      end
      WAIT_ACK: begin
        if (rom_ev) errc_d = sat_inc(errc_q);
        if (port_ack[sel_q] == req_q[sel_q]) begin
          state_d = IDLE;
          wait_d  = 1'b0;
        end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          // Give up without undoing the toggle; the port may still complete it later.
          state_d = IDLE;
          wait_d  = 1'b0;
          errt_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dip_ev) begin
      for (int j = 0; j < DIP_BYTES; j++) begin
        if (ioctl_addr == 25'(j)) dip_d[8*j +: 8] = ioctl_dout;
      end
    end

    idx_d    = (ioctl_download & ~dl_q) ? ioctl_index : idx_q;
    loaded_d = loaded_q | (dl_q & ~ioctl_download & (idx_q == ROM_IDX));

    if (user_reset | ioctl_download | ~loaded_q) hold_d = HOLD_W'(RESET_HOLD);
    else if (hold_q != '0)                       hold_d = hold_q - 1'b1;
    else                                         hold_d = hold_q;
    core_d = (hold_q != '0);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      a_q      <= '0;
      ds_q     <= '0;
      d_q      <= '0;
      wait_q   <= 1'b0;
      sel_q    <= '0;
      tmr_q    <= '0;
      errc_q   <= '0;
      errt_q   <= 1'b0;
      dip_q    <= '0;
      wr_q     <= 1'b0;
      dl_q     <= 1'b0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
      hold_q   <= HOLD_W'(RESET_HOLD);
      core_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      a_q      <= a_d;
      ds_q     <= ds_d;
      d_q      <= d_d;
      wait_q   <= wait_d;
      sel_q    <= sel_d;
      tmr_q    <= tmr_d;
      errc_q   <= errc_d;
      errt_q   <= errt_d;
      dip_q    <= dip_d;
      wr_q     <= ioctl_wr;
      dl_q     <= ioctl_download;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
      hold_q   <= hold_d;
      core_q   <= core_d;
    end
  end

  assign ioctl_wait   = wait_q;
  assign port_req     = req_q;
  assign port_a       = a_q;
  assign port_ds      = ds_q;
  assign port_d       = d_q;
  assign core_reset   = core_q;
  assign rom_loaded   = loaded_q;
  assign dip_sw       = dip_q;
  assign err_unmapped = errc_q;
  assign err_timeout  = errt_q;

endmodule

// File: tb/tb_ioctl_region_loader.sv
// Directed bench for ioctl_region_loader with default regions and a short post-load hold.
module tb_ioctl_region_loader;

  localparam int H = 40;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [3:0]  port_req;
  logic [3:0]  port_ack;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        user_reset;
  logic        core_reset;
  logic        rom_loaded;
  logic [63:0] dip_sw;
  logic [7:0]  err_unmapped;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;
  int n;
  int errc;

  ioctl_region_loader #(.RESET_HOLD(H)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
    .port_d(port_d), .user_reset(user_reset), .core_reset(core_reset),
    .rom_loaded(rom_loaded), .dip_sw(dip_sw), .err_unmapped(err_unmapped),
    .err_timeout(err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dout);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = dout;
    ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    ioctl_wr    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0; port_ack = '0; user_reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("rst_wait", 64'(ioctl_wait), 64'(0));
    chk("rst_req", 64'(port_req), 64'(0));
    chk("rst_core", 64'(core_reset), 64'(1));
    chk("rst_loaded", 64'(rom_loaded), 64'(0));
    chk("rst_dip", dip_sw, 64'(0));
    chk("rst_err", 64'(err_unmapped), 64'(0));
    reset = 1'b0;

    // Handshake into region 2
    ioctl_index = 8'd0;
    @(negedge clk_sys); ioctl_download = 1'b1;
    wr_byte(8'd0, 25'h0A003, 8'h5A);
    chk("r2_req", 64'(port_req), 64'(4'b0100));
    chk("r2_a", 64'(port_a), 64'(1));
    chk("r2_ds", 64'(port_ds), 64'(2'b10));
    chk("r2_d", 64'(port_d), 64'(16'h5A5A));
    chk("r2_wait", 64'(ioctl_wait), 64'(1));
    repeat (2) @(negedge clk_sys);
    chk("r2_wait_hold", 64'(ioctl_wait), 64'(1));
    chk("r2_a_stable", 64'(port_a), 64'(1));
    port_ack[2] = 1'b1;
    #1 chk("r2_wait_pre", 64'(ioctl_wait), 64'(1));
    @(negedge clk_sys);
    chk("r2_wait_done", 64'(ioctl_wait), 64'(0));

    // Region 3, with a ROM byte arriving mid-handshake
    errc = 0;
    wr_byte(8'd0, 25'h10004, 8'h11);
    chk("r3_req", 64'(port_req), 64'(4'b1100));
    chk("r3_a", 64'(port_a), 64'(2));
    chk("r3_ds", 64'(port_ds), 64'(2'b01));
    wr_byte(8'd0, 25'h00000, 8'h77);
    errc++;
    chk("busy_err", 64'(err_unmapped), 64'(errc));
    chk("busy_req", 64'(port_req), 64'(4'b1100));
    chk("busy_d", 64'(port_d), 64'(16'h1111));
    port_ack[3] = 1'b1;
    @(negedge clk_sys);
    chk("r3_done", 64'(ioctl_wait), 64'(0));

    // Unmapped bytes and saturation
    wr_byte(8'd0, 25'h1C000, 8'h01);
    errc++;
    chk("unm_err", 64'(err_unmapped), 64'(errc));
    chk("unm_req", 64'(port_req), 64'(4'b1100));
    chk("unm_wait", 64'(ioctl_wait), 64'(0));
    for (int i = 0; i < 299; i++) wr_byte(8'd0, 25'h1C000, 8'h02);
    chk("unm_sat", 64'(err_unmapped), 64'(255));

    // Last byte of region 3
    wr_byte(8'd0, 25'h1BFFF, 8'hC3);
    chk("r3_top_req", 64'(port_req), 64'(4'b0100));
    chk("r3_top_a", 64'(port_a), 64'(23'h5FFF));
    chk("r3_top_ds", 64'(port_ds), 64'(2'b10));
    port_ack[3] = 1'b0;
    @(negedge clk_sys);
    chk("r3_top_done", 64'(ioctl_wait), 64'(0));

    // Region 0 never acked: wait high for ACK_TIMEOUT cycles
    wr_byte(8'd0, 25'h00010, 8'h9C);
    chk("to_req", 64'(port_req), 64'(4'b0101));
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (!ioctl_wait) break;
      n++;
      @(negedge clk_sys);
    end
    chk("to_cycles", 64'(n), 64'(255));
    chk("to_flag", 64'(err_timeout), 64'(1));
    chk("to_req_kept", 64'(port_req), 64'(4'b0101));
    wr_byte(8'd0, 25'h08001, 8'h33);
    chk("r1_req", 64'(port_req), 64'(4'b0111));
    chk("r1_a", 64'(port_a), 64'(0));
    chk("r1_ds", 64'(port_ds), 64'(2'b10));
    chk("r1_d", 64'(port_d), 64'(16'h3333));
    chk("r1_wait", 64'(ioctl_wait), 64'(1));
    port_ack[1] = 1'b1;
    @(negedge clk_sys);
    chk("r1_done", 64'(ioctl_wait), 64'(0));

    // End of ROM download: rom_loaded appears one sample before the first countdown
    // step, so core_reset reads 1 on H+1 samples once rom_loaded is seen.
    chk("pre_loaded", 64'(rom_loaded), 64'(0));
    chk("pre_core", 64'(core_reset), 64'(1));
    ioctl_download = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      if (rom_loaded) break;
    end
    chk("loaded", 64'(rom_loaded), 64'(1));
    for (int k = 0; k < 4*H; k++) begin
      if (!core_reset) break;
      n++;
      @(negedge clk_sys);
    end
    chk("hold_rom", 64'(n), 64'(H + 1));
    chk("core_off", 64'(core_reset), 64'(0));
    user_reset = 1'b1;
    @(negedge clk_sys); user_reset = 1'b0;
    @(negedge clk_sys);
    n = 0;
    for (int k = 0; k < 4*H; k++) begin
      if (!core_reset) break;
      n++;
      @(negedge clk_sys);
    end
    chk("hold_user", 64'(n), 64'(H));

    // DIP download, plus an event with a foreign index
    ioctl_index = 8'd254;
    @(negedge clk_sys); ioctl_download = 1'b1;
    wr_byte(8'd254, 25'd3, 8'hA5);
    wr_byte(8'd254, 25'd9, 8'hFF);
    chk("dip_a5", dip_sw, 64'h00000000_A5000000);
    wr_byte(8'd254, 25'd7, 8'h12);
    chk("dip_top", dip_sw, 64'h12000000_A5000000);
    wr_byte(8'd5, 25'h08002, 8'h44);
    chk("other_req", 64'(port_req), 64'(4'b0111));
    chk("other_wait", 64'(ioctl_wait), 64'(0));
    chk("other_dip", dip_sw, 64'h12000000_A5000000);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("loaded_sticky", 64'(rom_loaded), 64'(1));

    // Reset in the middle of a handshake
    ioctl_index = 8'd0;
    @(negedge clk_sys); ioctl_download = 1'b1;
    wr_byte(8'd0, 25'h0A003, 8'h5A);
    chk("mid_req", 64'(port_req), 64'(4'b0011));
    chk("mid_wait", 64'(ioctl_wait), 64'(1));
    reset = 1'b1;
    #1;
    chk("arst_wait", 64'(ioctl_wait), 64'(0));
    chk("arst_req", 64'(port_req), 64'(0));
    chk("arst_core", 64'(core_reset), 64'(1));
    chk("arst_loaded", 64'(rom_loaded), 64'(0));
    chk("arst_dip", dip_sw, 64'(0));
    port_ack = '0; ioctl_download = 1'b0;
    @(negedge clk_sys); reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("post_req", 64'(port_req), 64'(0));
    chk("post_wait", 64'(ioctl_wait), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
